// File: rtl/if_prefetch_pkg.sv
// if_prefetch_pkg: shared widths, reset PC and the ID-bound entry layout {pc, inst, ex_ADEF}.
package if_prefetch_pkg;
    localparam int to_ID_data_width = 65;
    localparam int br_data_width = 33;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
    localparam int ADEF_BIT = 0;

    function automatic logic [to_ID_data_width-1:0] pack_id(input logic [31:0] pc, input logic [31:0] inst, input logic adef);
        logic [to_ID_data_width-1:0] d;
        d = {pc, inst, 1'b0};
        d[ADEF_BIT] = adef;
        return d;
    endfunction
endpackage

// File: rtl/if_inst_fifo.sv
// if_inst_fifo: synchronous FIFO with flush; simultaneous push and pop are both honoured,
// including push while full when a pop frees the slot in the same cycle.
module if_inst_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic do_push, do_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout = mem[rd];

    always_ff @(posedge clk)
        if (do_push && !flush) mem[wr] <= din;

    always_ff @(posedge clk)
        if (reset || flush) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= inc(wr);
            if (do_pop) rd <= inc(rd);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: multi-outstanding instruction fetch with an instruction buffer toward ID;
// redirects flush the buffer and discard every response still in flight.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int MAX_OUTSTANDING = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          csr_reset,
    input  logic [31:0]                   ex_entry,
    input  logic [br_data_width-1:0]      br_data,
    output logic                          inst_sram_req,
    output logic                          inst_sram_wr,
    output logic [1:0]                    inst_sram_size,
    output logic [3:0]                    inst_sram_wstrb,
    output logic [31:0]                   inst_sram_addr,
    output logic [31:0]                   inst_sram_wdata,
    input  logic                          inst_sram_addr_ok,
    input  logic                          inst_sram_data_ok,
    input  logic [31:0]                   inst_sram_rdata,
    input  logic                          ID_allow_in,
    output logic                          IF_to_ID_valid,
    output logic [to_ID_data_width-1:0]   to_ID_data
);
    localparam int IW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int PCW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0] fetch_pc, target, pcq_head;
    logic [IW-1:0] inflight, cancel_cnt;
    logic adef_sent, redirect, misaligned, accept, rsp, keep, adef_push, room;
    logic fifo_push, fifo_pop, fifo_full, fifo_empty, pcq_full, pcq_empty;
    logic [FCW-1:0] fifo_count;
    logic [PCW-1:0] pcq_count;
    logic [to_ID_data_width-1:0] fifo_din;
    logic unused_ok;

    assign redirect = csr_reset | br_data[32];
    assign target = csr_reset ? ex_entry : br_data[31:0];
    assign misaligned = |fetch_pc[1:0];
    // Every issued request owns a buffer slot, so data_ok never needs back-pressure.
    assign room = 32'(inflight) + 32'(fifo_count) < 32'(FIFO_DEPTH);
    assign inst_sram_req = ~reset & ~redirect & ~misaligned & (32'(inflight) < 32'(MAX_OUTSTANDING)) & room;
    assign inst_sram_addr = fetch_pc;
    assign inst_sram_wr = 1'b0;
    assign inst_sram_size = 2'b10;
    assign inst_sram_wstrb = 4'b0;
    assign inst_sram_wdata = 32'b0;
    assign accept = inst_sram_req & inst_sram_addr_ok;
    assign rsp = inst_sram_data_ok & ~pcq_empty;
    assign keep = rsp & (cancel_cnt == '0);
    assign adef_push = misaligned & ~adef_sent & (inflight == '0) & ~fifo_full & ~redirect;
    assign fifo_push = keep | adef_push;
    assign fifo_din = adef_push ? pack_id(fetch_pc, 32'b0, 1'b1) : pack_id(pcq_head, inst_sram_rdata, 1'b0);
    assign IF_to_ID_valid = ~fifo_empty & ~redirect & ~reset;
    assign fifo_pop = IF_to_ID_valid & ID_allow_in;
    assign unused_ok = ^{pcq_count, pcq_full};

    if_inst_fifo #(.WIDTH(to_ID_data_width), .DEPTH(FIFO_DEPTH)) u_inst_fifo (
        .clk(clk), .reset(reset), .push(fifo_push), .pop(fifo_pop), .flush(redirect),
        .din(fifo_din), .dout(to_ID_data), .count(fifo_count), .full(fifo_full), .empty(fifo_empty)
    );

    if_inst_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pc_queue (
        .clk(clk), .reset(reset), .push(accept), .pop(rsp), .flush(1'b0),
        .din(fetch_pc), .dout(pcq_head), .count(pcq_count), .full(pcq_full), .empty(pcq_empty)
    );

    // After a redirect, everything still outstanding belongs to the old stream.
    always_ff @(posedge clk)
        if (reset) begin
            fetch_pc <= RESET_PC;
            inflight <= '0;
            cancel_cnt <= '0;
            adef_sent <= 1'b0;
        end else begin
            inflight <= inflight + IW'(accept) - IW'(rsp);
            if (redirect) begin
                fetch_pc <= target;
                cancel_cnt <= inflight - IW'(rsp);
                adef_sent <= 1'b0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                if (rsp && cancel_cnt != '0) cancel_cnt <= cancel_cnt - IW'(1);
                if (adef_push) adef_sent <= 1'b1;
            end
        end
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: randomized SRAM/ID/redirect stimulus checked against a queue-based
// model of the fetch stream (request epochs, expected PC, expected ID buffer contents).
module tb_if_prefetch;
    import if_prefetch_pkg::*;

    localparam int MO = 2;
    localparam int FD = 4;
    localparam logic [31:0] RST_PC = 32'h1c000000;

    logic clk = 0, reset = 1, csr_reset = 0, inst_sram_addr_ok = 0, inst_sram_data_ok = 0, ID_allow_in = 0;
    logic [31:0] ex_entry = 0, inst_sram_rdata = 0;
    logic [br_data_width-1:0] br_data = 0;
    logic inst_sram_req, inst_sram_wr, IF_to_ID_valid;
    logic [1:0] inst_sram_size;
    logic [3:0] inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic [to_ID_data_width-1:0] to_ID_data;

    if_prefetch #(.RESET_PC(RST_PC), .MAX_OUTSTANDING(MO), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .csr_reset(csr_reset), .ex_entry(ex_entry), .br_data(br_data),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata), .ID_allow_in(ID_allow_in),
        .IF_to_ID_valid(IF_to_ID_valid), .to_ID_data(to_ID_data)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; logic [31:0] data; int epoch; int due;} req_t;
    req_t os[$];
    logic [64:0] q[$];
    logic [31:0] mpc = RST_PC;
    bit adef = 0;
    int epoch = 0, cyc = 0, tests = 0, fails = 0;
    int allow_pct = 100, ok_pct = 100, max_lat = 1, redir_pct = 0;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = {16'h1c00, 16'($urandom)};
        t[1:0] = ($urandom_range(99) < 10) ? 2'b10 : 2'b00;
        return t;
    endfunction

    task automatic step(input bit rst, input bit fbr = 0, input bit fcsr = 0, input logic [31:0] ftgt = 0);
        bit redir, ereq, evalid, rsp, acc, adefp;
        logic [31:0] tgt;
        req_t r;
        @(negedge clk);
        reset = rst;
        csr_reset = fcsr | (!fbr && $urandom_range(299) < redir_pct);
        ex_entry = fcsr ? 32'h1c008000 : rand_target();
        br_data = {fbr | ($urandom_range(99) < redir_pct), fbr ? ftgt : rand_target()};
        ID_allow_in = $urandom_range(99) < allow_pct;
        inst_sram_addr_ok = $urandom_range(99) < ok_pct;
        rsp = !rst && os.size() > 0 && os[0].due <= cyc && $urandom_range(99) < ok_pct;
        inst_sram_data_ok = rsp;
        inst_sram_rdata = rsp ? os[0].data : $urandom;
        #1;
        redir = csr_reset | br_data[32];
        tgt = csr_reset ? ex_entry : br_data[31:0];
        ereq = !rst && !redir && mpc[1:0] == 2'b00 && os.size() < MO && os.size() + q.size() < FD;
        evalid = !rst && !redir && q.size() > 0;
        check("req", 65'(inst_sram_req), 65'(ereq));
        if (ereq) check("addr", 65'(inst_sram_addr), 65'(mpc));
        check("valid", 65'(IF_to_ID_valid), 65'(evalid));
        if (evalid && IF_to_ID_valid) check("id_data", to_ID_data, q[0]);
        acc = ereq && inst_sram_addr_ok;
        adefp = !rst && !redir && mpc[1:0] != 2'b00 && !adef && os.size() == 0 && q.size() < FD;
        if (rst) begin
            os.delete();
            q.delete();
            mpc = RST_PC;
            adef = 0;
        end else begin
            if (rsp) begin
                r = os.pop_front();
                if (!redir && r.epoch == epoch) q.push_back({r.addr, r.data, 1'b0});
            end
            if (evalid && ID_allow_in) void'(q.pop_front());
            if (redir) begin
                q.delete();
                mpc = tgt;
                adef = 0;
                epoch++;
            end else begin
                if (acc) begin
                    os.push_back('{mpc, $urandom, epoch, cyc + int'($urandom_range(max_lat, 1))});
                    mpc += 4;
                end
                if (adefp) begin
                    q.push_back({mpc, 32'b0, 1'b1});
                    adef = 1;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        repeat (3) step(1);
        check("wr", 65'(inst_sram_wr), 65'(0));
        check("size", 65'(inst_sram_size), 65'(2));
        check("wstrb", 65'(inst_sram_wstrb), 65'(0));
        check("wdata", 65'(inst_sram_wdata), 65'(0));
        repeat (30) step(0);
        allow_pct = 0;
        repeat (10) step(0);
        allow_pct = 100;
        repeat (20) step(0);
        max_lat = 3;
        repeat (6) step(0);
        step(0, 1, 0, 32'h1c000100);
        repeat (12) step(0);
        step(0, 1, 1, 32'h1c000100);
        repeat (8) step(0);
        step(0, 1, 0, 32'h1c000102);
        repeat (10) step(0);
        step(0, 0, 1);
        repeat (10) step(0);
        allow_pct = 70;
        ok_pct = 70;
        redir_pct = 6;
        repeat (3000) step(0);
        repeat (2) step(1);
        max_lat = 1;
        ok_pct = 90;
        repeat (1500) step(0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
